// File: rtl/md_issue_ctrl_pkg.sv
// Shared MD-class definitions: op codes, op classification helpers and default
// MDU latencies. Used by the issue controller, the MDU and the decoder.
package md_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'b0000,
    MD_MULTU = 4'b0001,
    MD_DIV   = 4'b0010,
    MD_DIVU  = 4'b0011,
    MD_MFHI  = 4'b0100,
    MD_MFLO  = 4'b0101,
    MD_MTHI  = 4'b0110,
    MD_MTLO  = 4'b0111
  } md_op_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  // Codes 1xxx are not MD ops.
  function automatic logic is_md_legal(input logic [3:0] op);
    return !op[3];
  endfunction

  // mult/multu/div/divu occupy the MDU; moves do not.
  function automatic logic is_mul_div(input logic [3:0] op);
    return (op[3:2] == 2'b00);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op[3:1] == 3'b001);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_occ_counter.sv
// Occupancy mirror of the MDU: loads on an issued mult/div, counts down to 0.
module md_occ_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nz_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nz_o  = (cnt_q != '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage MD issue controller: registers op/start to the MDU and stalls D while
// a mult/div is in flight. Optional mirror/MDU divergence checker: MD_ISSUE_CHECK_EN.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_md_en,
  input  logic [3:0] d_md_op,
  input  logic       mdu_busy,
  output logic       md_stall,
  output logic       issue_valid,
  output logic [3:0] issue_op,
  output logic       issue_start,
  output logic       inflight,
  output logic       chk_err
);

  // The +1 covers the issue cycle so the next op issues only after HI/LO commit.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             cnt_nz;
  logic             md_req;
  logic             accept;
  logic             load;
  logic [CNT_W-1:0] load_val;

  logic             issue_valid_q, issue_valid_d;
  logic [3:0]       issue_op_q, issue_op_d;
  logic             issue_start_q, issue_start_d;

  assign md_req   = d_md_en && is_md_legal(d_md_op);
  assign md_stall = md_req && cnt_nz;
  assign accept   = md_req && !cnt_nz;
  assign load     = accept && is_mul_div(d_md_op);
  assign load_val = is_div(d_md_op) ? DIV_LOAD : MULT_LOAD;

  md_occ_counter #(
    .CNT_W(CNT_W)
  ) u_occ (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .load_val_i(load_val),
    .cnt_o     (cnt),
    .nz_o      (cnt_nz)
  );

  always_comb begin
    issue_valid_d = accept;
    issue_start_d = load;
    issue_op_d    = issue_op_q;
    if (accept) begin
      issue_op_d = d_md_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_valid_q <= 1'b0;
      issue_op_q    <= 4'b0000;
      issue_start_q <= 1'b0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_op_q    <= issue_op_d;
      issue_start_q <= issue_start_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_op    = issue_op_q;
  assign issue_start = issue_start_q;
  assign inflight    = cnt_nz;

`ifdef MD_ISSUE_CHECK_EN
  logic chk_err_q, chk_err_d;

  always_comb begin
    chk_err_d = chk_err_q;
    if ((mdu_busy && !cnt_nz) ||
        (!mdu_busy && (cnt > CNT_W'(2)) && !issue_valid_q)) begin
      chk_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  logic unused_mdu_busy;
  assign unused_mdu_busy = mdu_busy;
  assign chk_err         = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed vector bench for md_issue_ctrl: per-cycle table plus checker sequence.
module tb_md_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_md_en;
  logic [3:0] d_md_op;
  logic       mdu_busy;
  logic       md_stall;
  logic       issue_valid;
  logic [3:0] issue_op;
  logic       issue_start;
  logic       inflight;
  logic       chk_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_md_en    (d_md_en),
    .d_md_op    (d_md_op),
    .mdu_busy   (mdu_busy),
    .md_stall   (md_stall),
    .issue_valid(issue_valid),
    .issue_op   (issue_op),
    .issue_start(issue_start),
    .inflight   (inflight),
    .chk_err    (chk_err)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] op;
    logic       stall;
    logic       vld;
    logic [3:0] iop;
    logic       start;
    logic       infl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic en, logic [3:0] op, logic stall,
                              logic vld, logic [3:0] iop, logic start, logic infl);
    vec_t v;
    v.rst = rst; v.en = en; v.op = op; v.stall = stall;
    v.vld = vld; v.iop = iop; v.start = start; v.infl = infl;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [3:0] act,
                       input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    // Each row: inputs driven in a cycle, outputs expected in that same cycle.
    // rst  en   op       stall vld  iop      start infl
    vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 0, 0)); // 0  reset held
    vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 0, 0)); // 1  reset held
    vecs.push_back(mk(1, 1, 4'b0000, 0, 0, 4'b0000, 0, 0)); // 2  mult accepted (N)
    vecs.push_back(mk(1, 0, 4'b0000, 0, 1, 4'b0000, 1, 1)); // 3  cnt 6, non-MD no stall
    for (int k = 0; k < 5; k++)                              // 4..8 cnt 5..1
      vecs.push_back(mk(1, 1, 4'b0101, 1, 0, 4'b0000, 0, 1));
    vecs.push_back(mk(1, 1, 4'b0101, 0, 0, 4'b0000, 0, 0)); // 9  mflo accepted
    vecs.push_back(mk(1, 1, 4'b0110, 0, 1, 4'b0101, 0, 0)); // 10 mflo issued, mthi acc
    vecs.push_back(mk(1, 1, 4'b0111, 0, 1, 4'b0110, 0, 0)); // 11 mtlo acc
    vecs.push_back(mk(1, 1, 4'b0100, 0, 1, 4'b0111, 0, 0)); // 12 mfhi acc
    vecs.push_back(mk(1, 1, 4'b0011, 0, 1, 4'b0100, 0, 0)); // 13 divu acc (N)
    vecs.push_back(mk(1, 0, 4'b0000, 0, 1, 4'b0011, 1, 1)); // 14 cnt 11
    for (int k = 0; k < 10; k++)                             // 15..24 cnt 10..1
      vecs.push_back(mk(1, 1, 4'b0011, 1, 0, 4'b0011, 0, 1));
    vecs.push_back(mk(1, 1, 4'b0011, 0, 0, 4'b0011, 0, 0)); // 25 stall drops, divu acc
    vecs.push_back(mk(1, 0, 4'b0000, 0, 1, 4'b0011, 1, 1)); // 26 cnt 11
    vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 4'b0011, 0, 1)); // 27 cnt 10
    vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 4'b0011, 0, 1)); // 28 cnt 9
    vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 4'b0011, 0, 1)); // 29 cnt 8
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0011, 0, 1)); // 30 cnt 7, reset
    vecs.push_back(mk(1, 1, 4'b0000, 0, 0, 4'b0000, 0, 0)); // 31 mult acc, no stall
    vecs.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b0000, 1, 1)); // 32 issued, reset again
    vecs.push_back(mk(1, 1, 4'b1010, 0, 0, 4'b0000, 0, 0)); // 33 illegal op
    vecs.push_back(mk(1, 1, 4'b1111, 0, 0, 4'b0000, 0, 0)); // 34 illegal op
    vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 4'b0000, 0, 0)); // 35 nothing issued

    reset = 1'b0; d_md_en = 1'b0; d_md_op = 4'b0000; mdu_busy = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      reset    = vecs[i].rst;
      d_md_en  = vecs[i].en;
      d_md_op  = vecs[i].op;
      mdu_busy = vecs[i].infl;  // a consistent MDU keeps the checker quiet
      @(negedge clk);
      check("md_stall",    i, {3'b0, md_stall},    {3'b0, vecs[i].stall});
      check("issue_valid", i, {3'b0, issue_valid}, {3'b0, vecs[i].vld});
      check("issue_op",    i, issue_op,            vecs[i].iop);
      check("issue_start", i, {3'b0, issue_start}, {3'b0, vecs[i].start});
      check("inflight",    i, {3'b0, inflight},    {3'b0, vecs[i].infl});
      check("chk_err",     i, {3'b0, chk_err},     4'h0);
      @(posedge clk); #1;
    end

    // Checker: MDU claims busy while the mirror is idle.
    reset = 1'b1; d_md_en = 1'b0; mdu_busy = 1'b1;
    @(posedge clk); #1;
    mdu_busy = 1'b0;
    @(negedge clk);
`ifdef MD_ISSUE_CHECK_EN
    check("chk_err_set", 100, {3'b0, chk_err}, 4'h1);
`else
    check("chk_err_off", 100, {3'b0, chk_err}, 4'h0);
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
`ifdef MD_ISSUE_CHECK_EN
    check("chk_err_sticky", 101, {3'b0, chk_err}, 4'h1);
`else
    check("chk_err_off", 101, {3'b0, chk_err}, 4'h0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("chk_err_reset", 102, {3'b0, chk_err}, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
